// File: rtl/hfrv_trace_pkg.sv
// hfrv_trace_pkg: shared FSM states, opcode classes and classifier for the retire trace buffer.
// Optional build macro HFRV_TRACE_TIMESTAMP_EN is consumed by hfrv_trace_buffer.
package hfrv_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_POST   = 2'd1,
        ST_FROZEN = 2'd2
    } trace_state_e;

    typedef enum logic [2:0] {
        OC_LOAD, OC_STORE, OC_BRANCH, OC_JUMP, OC_OP, OC_OPIMM, OC_UPPER, OC_OTHER
    } opclass_e;

    localparam int NUM_CLASSES = 8;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    function automatic opclass_e opclass_of(input logic [6:0] opc);
        case (opc)
            OPC_LOAD:            return OC_LOAD;
            OPC_STORE:           return OC_STORE;
            OPC_BRANCH:          return OC_BRANCH;
            OPC_JAL, OPC_JALR:   return OC_JUMP;
            OPC_OP:              return OC_OP;
            OPC_OPIMM:           return OC_OPIMM;
            OPC_LUI, OPC_AUIPC:  return OC_UPPER;
            default:             return OC_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/hfrv_trace_ring.sv
// hfrv_trace_ring: circular entry store with occupancy count and sticky overwrite flag.
// Writes and pops are never requested in the same cycle by the owning FSM.
module hfrv_trace_ring #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full;

    assign full     = count_q == CW'(DEPTH);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (full) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                ovf_d    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (rd_en && count_q != '0) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            // draining the last entry ends the capture episode
            ovf_d    = (count_q == CW'(1)) ? 1'b0 : ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer: retire-stage trace capture with PC trigger, freeze/readout and opcode-class counters.
// Define HFRV_TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry and expose rd_ts.
module hfrv_trace_buffer
    import hfrv_trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ev_valid,
    input  logic [XLEN-1:0]        ev_pc,
    input  logic [31:0]            ev_instr,
    input  logic                   trig_en,
    input  logic [XLEN-1:0]        trig_pc,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [XLEN-1:0]        rd_pc,
    output logic [31:0]            rd_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [1:0]             state,
    input  logic [2:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_val,
    input  logic                   clr_cnt
`ifdef HFRV_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]            rd_ts
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
`ifdef HFRV_TRACE_TIMESTAMP_EN
        logic [31:0]     ts;
`endif
    } entry_t;

    trace_state_e     state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    entry_t           wr_e, rd_e;
    logic             frozen, wr_en, pop, hit;
    opclass_e         cls;

    assign frozen   = state_q == ST_FROZEN;
    assign wr_en    = ev_valid && !frozen;
    assign rd_valid = frozen && count != '0;
    assign pop      = rd_valid && rd_ready;
    assign hit      = ev_valid && trig_en && ev_pc == trig_pc;
    assign cls      = opclass_of(ev_instr[6:0]);
    assign state    = state_q;
    assign rd_pc    = rd_e.pc;
    assign rd_instr = rd_e.instr;
    assign cnt_val  = cnt_q[cnt_sel];
    assign wr_e.pc    = ev_pc;
    assign wr_e.instr = ev_instr;

`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;

    assign wr_e.ts = ts_q;
    assign rd_ts   = rd_e.ts;

    always_ff @(posedge clk) begin
        ts_q <= reset ? 32'd0 : ts_q + 32'd1;
    end
`endif

    hfrv_trace_ring #(.DEPTH(DEPTH), .W($bits(entry_t))) u_ring (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_e),
        .rd_en    (pop),
        .rd_data  (rd_e),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_RUN: if (hit) begin
                state_d = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                rem_d   = CW'(POST_TRIG);
            end
            ST_POST: if (ev_valid) begin
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == CW'(1)) ? ST_FROZEN : ST_POST;
            end
            ST_FROZEN: if (pop && count == CW'(1)) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // counters observe every retire regardless of trace state; clear beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) cnt_d = '{default: '0};
        else if (ev_valid && !(&cnt_q[cls])) cnt_d[cls] = cnt_q[cls] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
